// File: rtl/dnn_mem_responder_pkg.sv
// dnn_mem_pkg: address map and load-FSM state type shared by the
// DNN memory responder files.
//   ADDR_BASE_*  : first word of each region in the parameter/activation store
//   DEPTH        : total number of stored words
//   ld_state_t   : load sequencer states
package dnn_mem_pkg;

    localparam logic [15:0] ADDR_BASE_A      = 16'h0000;
    localparam logic [15:0] ADDR_BASE_W      = 16'h0191;
    localparam logic [15:0] ADDR_BASE_LUT_L1 = 16'h29BE;
    localparam logic [15:0] ADDR_BASE_LUT_L2 = 16'h29C6;
    localparam int          DEPTH            = 32'h0000_29CE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/dnn_mem_responder_if.sv
// dnn_mem_if: engine read port plus streaming load port of the memory
// responder.
//   master : engine/host side (drives mem_addr and ld_* requests/beats)
//   slave  : responder side (returns mem_data, ld_ready and load status)
interface dnn_mem_if
    import dnn_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 16
);
    logic        [ADDR_WIDTH-1:0] mem_addr;
    logic signed [DATA_WIDTH-1:0] mem_data;
    logic                         ld_start;
    logic        [ADDR_WIDTH-1:0] ld_base;
    logic        [ADDR_WIDTH-1:0] ld_len;
    logic                         ld_valid;
    logic                         ld_ready;
    logic signed [DATA_WIDTH-1:0] ld_data;
    logic                         ld_last;
    logic                         ld_busy;
    logic                         ld_done;
    logic                         ld_err;
    logic        [ADDR_WIDTH-1:0] words_loaded;

    modport master (
        output mem_addr, ld_start, ld_base, ld_len, ld_valid, ld_data, ld_last,
        input  mem_data, ld_ready, ld_busy, ld_done, ld_err, words_loaded
    );

    modport slave (
        input  mem_addr, ld_start, ld_base, ld_len, ld_valid, ld_data, ld_last,
        output mem_data, ld_ready, ld_busy, ld_done, ld_err, words_loaded
    );

endinterface

// File: rtl/dnn_mem_responder_array.sv
// dnn_mem_array: 1R1W synchronous RAM with read-first behaviour.
//   clk, rst : clock; rst clears only the read data register
//   rd_addr  : full-width read address; addresses >= DEPTH read as 0
//   rd_data  : registered read data, one cycle after rd_addr
//   wr_en    : write strobe
//   wr_addr  : write index (caller guarantees < DEPTH)
//   wr_data  : write data
module dnn_mem_array #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 32'h0000_29CE,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic        [ADDR_WIDTH-1:0] rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    input  logic                         wr_en,
    input  logic        [IDX_W-1:0]      wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic                         rd_in_range;

    // One extra bit keeps the comparison unsigned even when DEPTH needs
    // the full address width.
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    // Storage is never cleared; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read and write both use non-blocking updates on the same edge, so a
    // colliding read returns the word as it was before the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_in_range) begin
            rd_data <= mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/dnn_mem_responder.sv
// dnn_mem_responder: memory-side responder for the DNN engine read port with
// a streaming load port that fills any address window of the store.
//   clk  : clock
//   rst  : synchronous active-high reset (control and read register only)
//   bus  : dnn_mem_if slave modport
//          mem_addr/mem_data          engine read, one-cycle latency
//          ld_start/ld_base/ld_len    load request (taken only in IDLE)
//          ld_valid/ld_ready/ld_data/ld_last  load beats
//          ld_busy/ld_done/ld_err/words_loaded load status
module dnn_mem_responder
    import dnn_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = dnn_mem_pkg::DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    dnn_mem_if.slave bus
);

    localparam int                  IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

    ld_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    wr_en;
    logic [ADDR_WIDTH:0]     end_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Window length and write pointer are only meaningful inside a load.
    always_ff @(posedge clk) begin
        len_q <= len_d;
        ptr_q <= ptr_d;
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        // Extra bit so base+len cannot wrap before the range check.
        end_addr = {1'b0, bus.ld_base} + {1'b0, bus.ld_len};

        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    len_d = bus.ld_len;
                    ptr_d = bus.ld_base;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (bus.ld_len == '0) begin
                        state_d = DONE;
                    end else if (end_addr > DEPTH_X) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = DONE;
                    end else if (bus.ld_last) begin
                        // Early terminator: keep the word, abort the load.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ld_ready     = (state_q == LOAD);
    assign bus.ld_busy      = (state_q == LOAD);
    assign bus.ld_done      = (state_q == DONE);
    assign bus.ld_err       = err_q;
    assign bus.words_loaded = cnt_q;

    dnn_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (bus.mem_addr),
        .rd_data (bus.mem_data),
        .wr_en   (wr_en && !rst),
        .wr_addr (ptr_q[IDX_W-1:0]),
        .wr_data (bus.ld_data)
    );

endmodule

// File: tb/tb_dnn_mem_responder.sv
// Testbench for dnn_mem_responder: directed scenarios plus randomized loads,
// all checked against a word-level model of the store and load rules.
module tb_dnn_mem_responder;

    localparam int DW    = 3;
    localparam int AW    = 16;
    localparam int DEPTH = 32'h0000_29CE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dnn_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dnn_mem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int model [DEPTH];
    bit known [DEPTH];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input int a, input string tag);
        bus.mem_addr = a[15:0];
        tick();
        if (a >= DEPTH) chk(tag, bus.mem_data, 0);
        else if (known[a]) chk(tag, bus.mem_data, model[a]);
    endtask

    // One complete load request. Expected outcome comes from the load rules:
    // empty window -> done, window past DEPTH -> error, ld_last before the
    // final beat -> error after that beat, else done after len beats.
    // vpat != 0 gives a fixed valid pattern (bit n = cycle n), else vprob %.
    task automatic run_load(input int base, input int len, input int last_beat,
                            input int vprob, input int vpat, input bit seq,
                            input string tag);
        int  nbeats, acc, cyc, wa, v;
        bit  exp_err, exp_done, valid;
        if (len == 0) begin
            nbeats = 0; exp_done = 1; exp_err = 0;
        end else if (base + len > DEPTH) begin
            nbeats = 0; exp_done = 0; exp_err = 1;
        end else if (last_beat > 0 && last_beat < len) begin
            nbeats = last_beat; exp_done = 0; exp_err = 1;
        end else begin
            nbeats = len; exp_done = 1; exp_err = 0;
        end
        bus.ld_start = 1'b1;
        bus.ld_base  = base[15:0];
        bus.ld_len   = len[15:0];
        tick();
        bus.ld_start = 1'b0;
        if (len == 0) begin
            chk({tag, "_z_done"}, bus.ld_done, 1);
            chk({tag, "_z_busy"}, bus.ld_busy, 0);
            chk({tag, "_z_err"}, bus.ld_err, 0);
            tick();
            chk({tag, "_z_done_end"}, bus.ld_done, 0);
            return;
        end
        if (base + len > DEPTH) begin
            chk({tag, "_r_err"}, bus.ld_err, 1);
            chk({tag, "_r_busy"}, bus.ld_busy, 0);
            chk({tag, "_r_words"}, bus.words_loaded, 0);
            tick();
            chk({tag, "_r_busy2"}, bus.ld_busy, 0);
            chk({tag, "_r_err2"}, bus.ld_err, 1);
            return;
        end
        chk({tag, "_busy"}, bus.ld_busy, 1);
        chk({tag, "_err_clr"}, bus.ld_err, 0);
        chk({tag, "_words0"}, bus.words_loaded, 0);
        acc = 0;
        cyc = 0;
        while (acc < nbeats && cyc < 2000) begin
            valid = (vpat != 0) ? vpat[cyc % 32] : ($urandom_range(99) < vprob);
            wa = base + acc;
            v = seq ? (acc % 8) - 4 : int'($urandom_range(7)) - 4;
            bus.ld_valid = valid;
            bus.ld_data  = v[2:0];
            bus.ld_last  = (acc + 1 == last_beat);
            bus.mem_addr = wa[15:0];
            chk({tag, "_ready"}, bus.ld_ready, 1);
            tick();
            cyc++;
            if (known[wa]) chk({tag, "_rdfirst"}, bus.mem_data, model[wa]);
            if (valid) begin
                model[wa] = v;
                known[wa] = 1'b1;
                acc++;
            end
            chk({tag, "_words"}, bus.words_loaded, acc);
        end
        chk({tag, "_beats"}, acc, nbeats);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        chk({tag, "_done"}, bus.ld_done, exp_done);
        chk({tag, "_err"}, bus.ld_err, exp_err);
        chk({tag, "_busy_end"}, bus.ld_busy, 0);
        chk({tag, "_ready_end"}, bus.ld_ready, 0);
        tick();
        chk({tag, "_done_once"}, bus.ld_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int v, a, b, l, lb;
        rst          = 1'b1;
        bus.mem_addr = '0;
        bus.ld_start = 1'b0;
        bus.ld_base  = '0;
        bus.ld_len   = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        tick();
        tick();
        chk("rst_mem_data", bus.mem_data, 0);
        chk("rst_ready", bus.ld_ready, 0);
        chk("rst_busy", bus.ld_busy, 0);
        chk("rst_done", bus.ld_done, 0);
        chk("rst_err", bus.ld_err, 0);
        chk("rst_words", bus.words_loaded, 0);
        rst = 1'b0;
        tick();

        // LUT_L1 load with -4..3, ld_last on the final beat
        run_load('h29BE, 8, 8, 100, 0, 1'b1, "t1");
        chk("t1_words_final", bus.words_loaded, 8);
        for (int i = 0; i < 8; i++) begin
            read_chk('h29BE + i, "t1_read");
            chk("t1_read_val", bus.mem_data, i - 4);
        end

        // stalled beats: valid pattern 1,0,0,1,1,0,1
        run_load('h0010, 4, 0, 0, 'h59, 1'b0, "t2");
        for (int i = 0; i < 4; i++) read_chk('h10 + i, "t2_read");

        // fill to the very end of the store, then an out-of-range request
        run_load('h29C6, 8, 0, 70, 0, 1'b0, "t3_fill");
        bus.ld_valid = 1'b1;
        run_load('h29CC, 3, 0, 100, 0, 1'b0, "t3");
        bus.ld_valid = 1'b0;
        read_chk('h29CC, "t3_keep0");
        read_chk('h29CD, "t3_keep1");
        run_load('h0020, 2, 0, 100, 0, 1'b0, "t3_clear");

        // early ld_last on beat 2 of 5
        run_load('h0100, 5, 2, 100, 0, 1'b0, "t4");
        read_chk('h100, "t4_read0");
        read_chk('h101, "t4_read1");

        // colliding read/write (checked inside run_load), re-read, out of range
        run_load('h29BE, 8, 0, 60, 0, 1'b0, "t5");
        for (int i = 0; i < 8; i++) read_chk('h29BE + i, "t5_reread");
        read_chk('hFFFF, "t5_ffff");
        read_chk(DEPTH, "t5_depth");

        // reset in the middle of a 10-word load
        bus.ld_start = 1'b1;
        bus.ld_base  = 16'h0200;
        bus.ld_len   = 16'd10;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = int'($urandom_range(7)) - 4;
            bus.ld_valid = 1'b1;
            bus.ld_data  = v[2:0];
            tick();
            model['h200 + i] = v;
            known['h200 + i] = 1'b1;
        end
        bus.ld_valid = 1'b0;
        chk("t6_words_pre", bus.words_loaded, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", bus.ld_busy, 0);
        chk("t6_ready", bus.ld_ready, 0);
        chk("t6_done", bus.ld_done, 0);
        chk("t6_words", bus.words_loaded, 0);
        chk("t6_mem_data", bus.mem_data, 0);
        bus.ld_valid = 1'b1;
        tick();
        chk("t6_done_after", bus.ld_done, 0);
        chk("t6_words_drop", bus.words_loaded, 0);
        bus.ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) read_chk('h200 + i, "t6_retained");
        run_load('h0300, 0, 0, 100, 0, 1'b0, "t6_len0");

        // randomized loads and reads
        for (int n = 0; n < 12; n++) begin
            b = (n % 4 == 3) ? DEPTH - int'($urandom_range(6)) : int'($urandom_range(DEPTH - 1));
            l = int'($urandom_range(12));
            lb = 0;
            if (l > 0 && $urandom_range(3) == 0) lb = int'($urandom_range(l, 1));
            run_load(b, l, lb, int'($urandom_range(100, 30)), 0, 1'b0, "rnd");
            for (int k = 0; k < 4; k++) begin
                a = (l > 0) ? b + int'($urandom_range(l - 1)) : b;
                read_chk(a, "rnd_read");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
